// File: rtl/iq_boxcar.sv
// Accumulate-and-dump decimator for an interleaved I/Q stream: sums dec_len I/Q pairs per output.
// Optional build macro IQ_BOXCAR_ROUND_EN selects round-half-up with saturation instead of floor.
module iq_boxcar #(
   parameter int unsigned DW = 17,
   parameter int unsigned LW = 8,
   parameter int unsigned OW = 25
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic signed [DW-1:0] iq_data,
   input  logic                 iq_sel,
   input  logic                 gate,
   input  logic [LW-1:0]        dec_len,
   output logic signed [OW-1:0] i_out,
   output logic signed [OW-1:0] q_out,
   output logic                 out_valid,
   output logic                 sync_err
);

   localparam int unsigned AW = DW + LW;
   localparam int unsigned SH = AW - OW;

   typedef enum logic [1:0] {StSync, StWantQ, StWantI} state_e;

   state_e               state_q, state_d;
   logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [LW-1:0]        cnt_q, cnt_d, len_q, len_d;
   logic signed [OW-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
   logic                 valid_q, valid_d, err_q, err_d;

   logic                 acc_i_en, acc_q_en, last_pair;
   logic signed [AW-1:0] sample, q_sum;

`ifdef IQ_BOXCAR_ROUND_EN
   localparam int unsigned RndSh = (SH > 0) ? SH - 1 : 0;
   localparam logic signed [AW:0] Rnd = (SH > 0) ? ((AW+1)'(1) << RndSh) : '0;
   localparam logic signed [AW:0] OutMax = (AW+1)'((64'd1 << (OW - 1)) - 64'd1);
`endif

   function automatic logic signed [OW-1:0] scale(input logic signed [AW-1:0] acc);
      logic signed [AW:0] ext;
      logic signed [AW:0] shifted;
      ext = {acc[AW-1], acc};
`ifdef IQ_BOXCAR_ROUND_EN
      ext = ext + Rnd;
      shifted = ext >>> SH;
      // Only the rounding increment can push a positive sum past the output range.
      if (shifted > OutMax) begin
         return OutMax[OW-1:0];
      end
      return $signed(shifted[OW-1:0]);
`else
      shifted = ext >>> SH;
      return $signed(shifted[OW-1:0]);
`endif
   endfunction

   assign acc_i_en  = gate & iq_sel;
   assign acc_q_en  = gate & ~iq_sel;
   assign sample    = {{LW{iq_data[DW-1]}}, iq_data};
   assign q_sum     = acc_q_q + sample;
   assign last_pair = (cnt_q == len_q - LW'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StSync;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSync: begin
            if (acc_i_en) state_d = StWantQ;
         end
         StWantQ: begin
            if (acc_q_en) state_d = last_pair ? StSync : StWantI;
            else if (acc_i_en) state_d = StWantQ;
         end
         StWantI: begin
            if (acc_i_en) state_d = StWantQ;
            else if (acc_q_en) state_d = StSync;
         end
         default: state_d = StSync;
      endcase
   end

   always_comb begin
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      i_out_d = i_out_q;
      q_out_d = q_out_q;
      valid_d = 1'b0;
      err_d   = err_q;
      // An I seen in StWantQ is both a pairing error and the start of a fresh block.
      if (acc_i_en && (state_q == StSync || state_q == StWantQ)) begin
         acc_i_d = sample;
         acc_q_d = '0;
         cnt_d   = '0;
         len_d   = (dec_len == '0) ? LW'(1) : dec_len;
         if (state_q == StWantQ) err_d = 1'b1;
      end
      unique case (state_q)
         StWantQ: begin
            if (acc_q_en) begin
               acc_q_d = q_sum;
               if (last_pair) begin
                  i_out_d = scale(acc_i_q);
                  q_out_d = scale(q_sum);
                  valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + LW'(1);
               end
            end
         end
         StWantI: begin
            if (acc_i_en) acc_i_d = acc_i_q + sample;
            else if (acc_q_en) err_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_i_q <= '0;
         acc_q_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         i_out_q <= '0;
         q_out_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         i_out_q <= i_out_d;
         q_out_q <= q_out_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign i_out     = i_out_q;
   assign q_out     = q_out_q;
   assign out_valid = valid_q;
   assign sync_err  = err_q;

endmodule
